// File: rtl/eth_phy_10g_pkg.sv
// ----------------------------------------------------------------------------
// eth_phy_10g_pkg
// Shared constants and types for the 10GBASE-R PHY gearbox blocks.
//   GBX_PERIOD / GBX_SEQ_MAX : 33-cycle gearbox period, last sequence index
//   BLOCK_WIDTH              : 66-bit {data, hdr} block
//   SYNC_DATA / SYNC_CTRL    : legal sync headers in wire order (bit 0 first)
//   gbx_seq_t                : gearbox sequence index type
// ----------------------------------------------------------------------------
package eth_phy_10g_pkg;

  localparam int unsigned GBX_PERIOD  = 33;
  localparam int unsigned GBX_SEQ_MAX = 32;
  localparam int unsigned BLOCK_WIDTH = 66;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;

  typedef logic [5:0] gbx_seq_t;

  // Anything other than a data or control sync header is illegal on the wire.
  function automatic logic is_bad_hdr(input logic [1:0] hdr);
    return (hdr != SYNC_DATA) && (hdr != SYNC_CTRL);
  endfunction

endpackage

// File: rtl/eth_phy_pipe_reg.sv
// ----------------------------------------------------------------------------
// eth_phy_pipe_reg
// Fixed-depth delay line with synchronous active-high reset to zero.
// DEPTH = 0 is a plain wire.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, clears every stage
//   din  : WIDTH-bit input
//   dout : din delayed by DEPTH cycles
// ----------------------------------------------------------------------------
module eth_phy_pipe_reg #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = clk ^ rst;
    assign dout          = din;
  end else begin : g_pipe
    localparam int unsigned SW = DEPTH * WIDTH;

    logic [DEPTH-1:0][WIDTH-1:0] stage;

    // Shift up by one word per cycle; stage[0] takes din.
    always_ff @(posedge clk) begin
      if (rst) begin
        stage <= '0;
      end else begin
        stage <= SW'({stage, din});
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/eth_phy_10g_tx_gearbox.sv
// ----------------------------------------------------------------------------
// eth_phy_10g_tx_gearbox
// 66:64 TX gearbox. Packs {data, hdr} blocks into a continuous 64-bit stream,
// bit 0 transmitted first, header ahead of data. One block is consumed on 32
// of every 33 cycles; on the 33rd the residue is flushed.
//   clk                  : TX clock, rising edge
//   rst                  : synchronous active-high reset
//   serdes_tx_data       : scrambled 64-bit block payload
//   serdes_tx_hdr        : 2-bit sync header, hdr[0] first on the wire
//   serdes_tx_ready      : high when the presented block is consumed this edge
//   gbx_tx_data          : gearboxed word, delayed GBX_PIPELINE extra cycles
//   gbx_tx_seq           : sequence index 0..32, aligned with serdes_tx_ready
//   cfg_tx_prbs31_enable : upstream PRBS31 active (header check only)
// Optional: define ETH_PHY_GBX_HDR_CHECK_EN to add tx_bad_hdr (one-cycle pulse
// on an accepted illegal header while PRBS31 is off) and tx_bad_hdr_count
// (saturating at 255).
// ----------------------------------------------------------------------------
module eth_phy_10g_tx_gearbox
  import eth_phy_10g_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned HDR_WIDTH    = 2,
  parameter int unsigned GBX_PIPELINE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] serdes_tx_data,
  input  logic [HDR_WIDTH-1:0]  serdes_tx_hdr,
  output logic                  serdes_tx_ready,
  output logic [DATA_WIDTH-1:0] gbx_tx_data,
  output gbx_seq_t              gbx_tx_seq,
`ifdef ETH_PHY_GBX_HDR_CHECK_EN
  output logic                  tx_bad_hdr,
  output logic [7:0]            tx_bad_hdr_count,
`endif
  input  logic                  cfg_tx_prbs31_enable
);

  localparam int unsigned BLK_W  = DATA_WIDTH + HDR_WIDTH;
  localparam int unsigned BUF_W  = 2 * DATA_WIDTH;
  localparam int unsigned WORK_W = BUF_W + HDR_WIDTH;
  localparam int unsigned CNT_W  = 7;

  localparam gbx_seq_t         SEQ_LAST = gbx_seq_t'(GBX_SEQ_MAX);
  localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(HDR_WIDTH);

  // Elaboration-time parameter guards.
  if (DATA_WIDTH != 64) begin : g_bad_data_width
    $fatal(1, "eth_phy_10g_tx_gearbox: DATA_WIDTH must be 64");
  end
  if (HDR_WIDTH != 2) begin : g_bad_hdr_width
    $fatal(1, "eth_phy_10g_tx_gearbox: HDR_WIDTH must be 2");
  end
  if (BLK_W != BLOCK_WIDTH) begin : g_bad_block_width
    $fatal(1, "eth_phy_10g_tx_gearbox: block width must be 66");
  end
  if (GBX_PIPELINE > 4) begin : g_bad_pipeline
    $fatal(1, "eth_phy_10g_tx_gearbox: GBX_PIPELINE must be 0..4");
  end

  gbx_seq_t              seq;
  logic [CNT_W-1:0]      cnt;
  logic [BUF_W-1:0]      res_buf;
  logic [DATA_WIDTH-1:0] data_q;

  logic                  accept_c;
  logic [BLK_W-1:0]      block_c;
  logic [WORK_W-1:0]     work_c;

  assign accept_c        = (seq != SEQ_LAST);
  assign serdes_tx_ready = accept_c && !rst;
  assign gbx_tx_seq      = seq;

  // Merge the new block above the residue; cnt is the residue fill in bits.
  always_comb begin
    block_c = {serdes_tx_data, serdes_tx_hdr};
    work_c  = {{HDR_WIDTH{1'b0}}, res_buf} | (WORK_W'(block_c) << cnt);
  end

  // Gearbox state: emit the low word of the merge, keep the rest as residue;
  // on the last sequence slot emit the leftover residue with no new block.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq     <= '0;
      cnt     <= '0;
      res_buf <= '0;
      data_q  <= '0;
    end else if (accept_c) begin
      data_q  <= work_c[DATA_WIDTH-1:0];
      res_buf <= BUF_W'(work_c >> DATA_WIDTH);
      cnt     <= cnt + CNT_STEP;
      seq     <= seq + gbx_seq_t'(1);
    end else begin
      data_q  <= res_buf[DATA_WIDTH-1:0];
      res_buf <= '0;
      cnt     <= '0;
      seq     <= '0;
    end
  end

  // Optional output retiming toward the SERDES.
  eth_phy_pipe_reg #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (GBX_PIPELINE)
  ) u_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  (data_q),
    .dout (gbx_tx_data)
  );

`ifdef ETH_PHY_GBX_HDR_CHECK_EN
  logic bad_c;

  assign bad_c = accept_c && is_bad_hdr(serdes_tx_hdr) && !cfg_tx_prbs31_enable;

  // Illegal-header monitor; PRBS31 traffic has no meaningful headers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_bad_hdr       <= 1'b0;
      tx_bad_hdr_count <= '0;
    end else begin
      tx_bad_hdr <= bad_c;
      if (bad_c && (tx_bad_hdr_count != 8'hFF)) begin
        tx_bad_hdr_count <= tx_bad_hdr_count + 8'd1;
      end
    end
  end
`else
  logic unused_prbs;
  assign unused_prbs = cfg_tx_prbs31_enable;
`endif

endmodule

// File: tb/tb_eth_phy_10g_tx_gearbox.sv
// ----------------------------------------------------------------------------
// tb_eth_phy_10g_tx_gearbox
// Self-checking bench for the 66:64 TX gearbox. Two instances share stimulus:
// GBX_PIPELINE=0 and GBX_PIPELINE=3. Accepted blocks are pushed LSB-first
// into a bit queue; each output word pops 64 bits from it.
// ----------------------------------------------------------------------------
module tb_eth_phy_10g_tx_gearbox;

  logic        clk;
  logic        rst;
  logic [63:0] serdes_tx_data;
  logic [1:0]  serdes_tx_hdr;
  logic        cfg_tx_prbs31_enable;

  logic        ready0, ready3;
  logic [63:0] data0, data3;
  logic [5:0]  seq0, seq3;
`ifdef ETH_PHY_GBX_HDR_CHECK_EN
  logic        bad0, bad3;
  logic [7:0]  bcnt0, bcnt3;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int blk_k    = 0;

  eth_phy_10g_tx_gearbox #(.GBX_PIPELINE(0)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .serdes_tx_data       (serdes_tx_data),
    .serdes_tx_hdr        (serdes_tx_hdr),
    .serdes_tx_ready      (ready0),
    .gbx_tx_data          (data0),
    .gbx_tx_seq           (seq0),
`ifdef ETH_PHY_GBX_HDR_CHECK_EN
    .tx_bad_hdr           (bad0),
    .tx_bad_hdr_count     (bcnt0),
`endif
    .cfg_tx_prbs31_enable (cfg_tx_prbs31_enable)
  );

  eth_phy_10g_tx_gearbox #(.GBX_PIPELINE(3)) dut_p3 (
    .clk                  (clk),
    .rst                  (rst),
    .serdes_tx_data       (serdes_tx_data),
    .serdes_tx_hdr        (serdes_tx_hdr),
    .serdes_tx_ready      (ready3),
    .gbx_tx_data          (data3),
    .gbx_tx_seq           (seq3),
`ifdef ETH_PHY_GBX_HDR_CHECK_EN
    .tx_bad_hdr           (bad3),
    .tx_bad_hdr_count     (bcnt3),
`endif
    .cfg_tx_prbs31_enable (cfg_tx_prbs31_enable)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  bit          bitq[$];
  logic [63:0] q3[$];
  int          mseq = 0;
  bit          mbad = 1'b0;
  int          mcnt = 0;

  // Scoreboard: update the model at each edge, compare shortly after it.
  always @(posedge clk) begin : monitor
    bit          r, p;
    logic [63:0] d;
    logic [1:0]  h;
    logic [63:0] w;
    r = rst;
    p = cfg_tx_prbs31_enable;
    d = serdes_tx_data;
    h = serdes_tx_hdr;
    w = '0;
    if (r) begin
      mseq = 0;
      mbad = 1'b0;
      mcnt = 0;
      bitq.delete();
      q3.delete();
      repeat (3) q3.push_back(64'h0);
    end else begin
      if (mseq != 32) begin
        for (int i = 0; i < 2; i++)  bitq.push_back(h[i]);
        for (int i = 0; i < 64; i++) bitq.push_back(d[i]);
        mseq++;
        mbad = ((h == 2'b00) || (h == 2'b11)) && !p;
        if (mbad && mcnt != 255) mcnt++;
      end else begin
        mseq = 0;
        mbad = 1'b0;
      end
      if (bitq.size() >= 64) begin
        for (int i = 0; i < 64; i++) w[i] = bitq.pop_front();
      end else begin
        check_eq("model_bits_avail", 64'(bitq.size()), 64'd64);
      end
    end
    q3.push_back(w);
    #1;
    check_eq("data_p0", data0, w);
    check_eq("seq_p0", 64'(seq0), 64'(mseq));
    check_eq("ready_p0", 64'(ready0), 64'((mseq != 32) && !rst));
    check_eq("data_p3", data3, q3.pop_front());
    check_eq("seq_p3", 64'(seq3), 64'(mseq));
    check_eq("ready_p3", 64'(ready3), 64'((mseq != 32) && !rst));
`ifdef ETH_PHY_GBX_HDR_CHECK_EN
    check_eq("bad_hdr", 64'(bad0), 64'(mbad));
    check_eq("bad_hdr_count", 64'(bcnt0), 64'(mcnt));
`endif
  end

  // One stimulus cycle: set rst at the falling edge, then present a block if
  // the gearbox will take it, otherwise a poison value that must never appear.
  task automatic cycle(input bit r, input int mode);
    @(negedge clk);
    rst = r;
    #1;
    if (ready0) begin
      case (mode)
        0: begin serdes_tx_data = 64'h0;              serdes_tx_hdr = 2'b10; end
        1: begin serdes_tx_data = 64'(blk_k);         serdes_tx_hdr = 2'b01; end
        default: begin
          serdes_tx_data = {32'hB0B0_0000, 32'(blk_k)}; serdes_tx_hdr = 2'b11;
        end
      endcase
      blk_k++;
    end else begin
      serdes_tx_data = 64'hDEAD_BEEF_0BAD_F00D;
      serdes_tx_hdr  = 2'b00;
    end
  endtask

  task automatic run_blocks(input int n, input int mode);
    int start;
    int guard;
    start = blk_k;
    guard = 0;
    while ((blk_k - start) < n && guard < 2 * n + 10) begin
      cycle(1'b0, mode);
      guard++;
    end
    check_eq("run_blocks_done", 64'(blk_k - start), 64'(n));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit found;
    rst                  = 1'b1;
    serdes_tx_data       = '0;
    serdes_tx_hdr        = 2'b00;
    cfg_tx_prbs31_enable = 1'b0;

    // Constant data=0, hdr=10 right after reset release.
    repeat (3) cycle(1'b1, 0);
    cycle(1'b0, 0);
    cycle(1'b0, 0);
    check_eq("first_word", data0, 64'h0000_0000_0000_0002);
    repeat (68) cycle(1'b0, 0);

    // Incrementing payload, control header, 200 blocks.
    repeat (2) cycle(1'b1, 1);
    blk_k = 0;
    run_blocks(200, 1);
    repeat (5) cycle(1'b0, 1);

    // Reset for one cycle while seq = 17.
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1);
      if (seq0 == 6'd16) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("seq16_reached", 64'(found), 64'd1);
    cycle(1'b1, 1);
    check_eq("seq_at_reset", 64'(seq0), 64'd17);
    cycle(1'b0, 1);
    check_eq("post_reset_data", data0, 64'h0);
    check_eq("post_reset_seq", 64'(seq0), 64'd0);
    check_eq("post_reset_ready", 64'(ready0), 64'd1);
    repeat (40) cycle(1'b0, 1);

    // Illegal headers, first with PRBS31 on, then off.
    repeat (2) cycle(1'b1, 2);
    cfg_tx_prbs31_enable = 1'b1;
    run_blocks(300, 2);
    cycle(1'b0, 2);
`ifdef ETH_PHY_GBX_HDR_CHECK_EN
    check_eq("prbs_count_zero", 64'(bcnt0), 64'd0);
`endif
    cfg_tx_prbs31_enable = 1'b0;
    run_blocks(300, 2);
    cycle(1'b0, 2);
    cycle(1'b0, 2);
`ifdef ETH_PHY_GBX_HDR_CHECK_EN
    check_eq("count_saturated", 64'(bcnt0), 64'd255);
`endif
    repeat (4) cycle(1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
